// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - N-to-1 SPI request arbiter (round-robin or fixed priority) with zero-latency data mux.
// Optional watchdog enabled by defining SPI_REQ_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
   parameter int NUM_REQ = 8,
   parameter int DSIZE   = 8,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 65535
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       clk_en,
   input  logic [NUM_REQ-1:0]         s_request,
   input  logic [NUM_REQ*24-1:0]      s_req_len,
   input  logic [NUM_REQ*24-1:0]      s_req_wr_len,
   input  logic [NUM_REQ*3-1:0]       s_req_cmd,
   output logic [NUM_REQ-1:0]         s_busy,
   output logic [NUM_REQ-1:0]         s_finish,
   input  logic [NUM_REQ-1:0]         s_wr_vld,
   input  logic [NUM_REQ*DSIZE-1:0]   s_wr_data,
   output logic [NUM_REQ-1:0]         s_wr_ready,
   input  logic [NUM_REQ-1:0]         s_rd_ready,
   output logic [NUM_REQ-1:0]         s_rd_vld,
   output logic [DSIZE-1:0]           s_rd_data,
   output logic                       m_request,
   output logic [23:0]                m_req_len,
   output logic [23:0]                m_req_wr_len,
   output logic [2:0]                 m_req_cmd,
   input  logic                       m_busy,
   input  logic                       m_finish,
   output logic                       m_wr_vld,
   output logic [DSIZE-1:0]           m_wr_data,
   input  logic                       m_wr_ready,
   output logic                       m_rd_ready,
   input  logic                       m_rd_vld,
   input  logic [DSIZE-1:0]           m_rd_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       timeout_err
);
   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FIN, RELEASE} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      g_q, g_d;
   logic [GW-1:0]      last_q, last_d;
   logic               m_request_q, m_request_d;
   logic [23:0]        len_q, len_d;
   logic [23:0]        wr_len_q, wr_len_d;
   logic [2:0]         cmd_q, cmd_d;
   logic [NUM_REQ-1:0] s_finish_q, s_finish_d;
   logic [GW-1:0]      win;
   logic               active;
   logic               tmo_hit;

   assign active = (state_q == ISSUE) || (state_q == WAIT_FIN);

   // Round-robin scans last_q+1 .. last_q+NUM_REQ modulo NUM_REQ; first hit wins.
   always_comb begin
      logic          found;
      int            idx;
      logic [GW-1:0] cand;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      if (MODE == 1) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = GW'(i);
            if (s_request[cand]) win = cand;
         end
      end else begin
         for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (!found && s_request[cand]) begin
               win   = cand;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      last_d      = last_q;
      m_request_d = m_request_q;
      len_d       = len_q;
      wr_len_d    = wr_len_q;
      cmd_d       = cmd_q;
      s_finish_d  = '0;
      case (state_q)
         IDLE: begin
            if (|s_request) begin
               g_d         = win;
               len_d       = s_req_len[win*24 +: 24];
               wr_len_d    = s_req_wr_len[win*24 +: 24];
               cmd_d       = s_req_cmd[win*3 +: 3];
               m_request_d = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE, WAIT_FIN: begin
            if (m_finish || tmo_hit) begin
               s_finish_d[g_q] = 1'b1;
               m_request_d     = 1'b0;
               state_d         = RELEASE;
            end else if ((state_q == ISSUE) && m_busy) begin
               m_request_d = 1'b0;
               state_d     = WAIT_FIN;
            end
         end
         RELEASE: begin
            last_d  = g_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         g_q         <= '0;
         last_q      <= GW'(NUM_REQ - 1);
         m_request_q <= 1'b0;
         len_q       <= '0;
         wr_len_q    <= '0;
         cmd_q       <= '0;
         s_finish_q  <= '0;
      end else if (clk_en) begin
         state_q     <= state_d;
         g_q         <= g_d;
         last_q      <= last_d;
         m_request_q <= m_request_d;
         len_q       <= len_d;
         wr_len_q    <= wr_len_d;
         cmd_q       <= cmd_d;
         s_finish_q  <= s_finish_d;
      end
   end

`ifdef SPI_REQ_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          err_q, err_d;

   assign cnt_inc = cnt_q + CW'(1);
   assign tmo_hit = active && (cnt_inc == CW'(TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q | tmo_hit;
      if ((state_q == IDLE) && (|s_request)) cnt_d = '0;
      else if (active)                       cnt_d = cnt_inc;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (clk_en) begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_err = err_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Data path follows the registered grant even while clk_en is low.
   always_comb begin
      s_wr_ready = '0;
      s_rd_vld   = '0;
      m_wr_vld   = 1'b0;
      m_rd_ready = 1'b0;
      m_wr_data  = s_wr_data[g_q*DSIZE +: DSIZE];
      if (active) begin
         m_wr_vld        = s_wr_vld[g_q];
         s_wr_ready[g_q] = m_wr_ready;
         m_rd_ready      = s_rd_ready[g_q];
         s_rd_vld[g_q]   = m_rd_vld;
      end
   end

   assign s_rd_data    = m_rd_data;
   assign s_busy       = {NUM_REQ{state_q != IDLE}};
   assign s_finish     = s_finish_q;
   assign m_request    = m_request_q;
   assign m_req_len    = len_q;
   assign m_req_wr_len = wr_len_q;
   assign m_req_cmd    = cmd_q;
   assign grant_idx    = g_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed bench: round-robin and fixed-priority arbiters driven in lockstep.
module tb_spi_req_arbiter;
   localparam int N = 8;
   localparam int D = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            rst_n, clk_en;
   logic [N-1:0]    s_request;
   logic [N*24-1:0] s_req_len, s_req_wr_len;
   logic [N*3-1:0]  s_req_cmd;
   logic [N-1:0]    s_wr_vld, s_rd_ready;
   logic [N*D-1:0]  s_wr_data;
   logic            m_busy, m_finish, m_wr_ready, m_rd_vld;
   logic [D-1:0]    m_rd_data;

   logic [N-1:0] r_s_busy, r_s_finish, r_s_wr_ready, r_s_rd_vld;
   logic [D-1:0] r_s_rd_data, r_m_wr_data;
   logic         r_m_request, r_m_wr_vld, r_m_rd_ready, r_timeout_err;
   logic [23:0]  r_m_req_len, r_m_req_wr_len;
   logic [2:0]   r_m_req_cmd, r_grant_idx;

   logic [N-1:0] f_s_busy, f_s_finish, f_s_wr_ready, f_s_rd_vld;
   logic [D-1:0] f_s_rd_data, f_m_wr_data;
   logic         f_m_request, f_m_wr_vld, f_m_rd_ready, f_timeout_err;
   logic [23:0]  f_m_req_len, f_m_req_wr_len;
   logic [2:0]   f_m_req_cmd, f_grant_idx;

   spi_req_arbiter #(.NUM_REQ(N), .DSIZE(D), .MODE(0), .TIMEOUT(16)) u_rr (
      .clock(clock), .rst_n(rst_n), .clk_en(clk_en),
      .s_request(s_request), .s_req_len(s_req_len), .s_req_wr_len(s_req_wr_len), .s_req_cmd(s_req_cmd),
      .s_busy(r_s_busy), .s_finish(r_s_finish),
      .s_wr_vld(s_wr_vld), .s_wr_data(s_wr_data), .s_wr_ready(r_s_wr_ready),
      .s_rd_ready(s_rd_ready), .s_rd_vld(r_s_rd_vld), .s_rd_data(r_s_rd_data),
      .m_request(r_m_request), .m_req_len(r_m_req_len), .m_req_wr_len(r_m_req_wr_len), .m_req_cmd(r_m_req_cmd),
      .m_busy(m_busy), .m_finish(m_finish),
      .m_wr_vld(r_m_wr_vld), .m_wr_data(r_m_wr_data), .m_wr_ready(m_wr_ready),
      .m_rd_ready(r_m_rd_ready), .m_rd_vld(m_rd_vld), .m_rd_data(m_rd_data),
      .grant_idx(r_grant_idx), .timeout_err(r_timeout_err)
   );

   spi_req_arbiter #(.NUM_REQ(N), .DSIZE(D), .MODE(1), .TIMEOUT(16)) u_fp (
      .clock(clock), .rst_n(rst_n), .clk_en(clk_en),
      .s_request(s_request), .s_req_len(s_req_len), .s_req_wr_len(s_req_wr_len), .s_req_cmd(s_req_cmd),
      .s_busy(f_s_busy), .s_finish(f_s_finish),
      .s_wr_vld(s_wr_vld), .s_wr_data(s_wr_data), .s_wr_ready(f_s_wr_ready),
      .s_rd_ready(s_rd_ready), .s_rd_vld(f_s_rd_vld), .s_rd_data(f_s_rd_data),
      .m_request(f_m_request), .m_req_len(f_m_req_len), .m_req_wr_len(f_m_req_wr_len), .m_req_cmd(f_m_req_cmd),
      .m_busy(m_busy), .m_finish(m_finish),
      .m_wr_vld(f_m_wr_vld), .m_wr_data(f_m_wr_data), .m_wr_ready(m_wr_ready),
      .m_rd_ready(f_m_rd_ready), .m_rd_vld(m_rd_vld), .m_rd_data(m_rd_data),
      .grant_idx(f_grant_idx), .timeout_err(f_timeout_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entered in IDLE with s_request already driven; leaves both arbiters in IDLE.
   task automatic serve(input int exp_rr, input int exp_fp);
      tick();
      chk("rr_grant", 32'(r_grant_idx), exp_rr);
      chk("fp_grant", 32'(f_grant_idx), exp_fp);
      chk("rr_m_request_issue", 32'(r_m_request), 1);
      m_busy = 1'b1;
      tick();
      chk("rr_m_request_wait", 32'(r_m_request), 0);
      m_busy   = 1'b0;
      m_finish = 1'b1;
      tick();
      chk("rr_s_finish", 32'(r_s_finish), 1 << exp_rr);
      chk("fp_s_finish", 32'(f_s_finish), 1 << exp_fp);
      m_finish = 1'b0;
      tick();
      chk("rr_s_finish_clear", 32'(r_s_finish), 0);
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b1;
      s_request = '0; s_req_len = '0; s_req_wr_len = '0; s_req_cmd = '0;
      s_wr_vld = '0; s_wr_data = '0; s_rd_ready = '0;
      m_busy = 1'b0; m_finish = 1'b0; m_wr_ready = 1'b0; m_rd_vld = 1'b0; m_rd_data = '0;
      for (int i = 0; i < N; i++) begin
         s_req_len[i*24 +: 24]    = 24'(i * 1000 + 1);
         s_req_wr_len[i*24 +: 24] = 24'(i * 10 + 2);
         s_req_cmd[i*3 +: 3]      = 3'(i);
      end
      repeat (3) tick();
      chk("rst_m_request", 32'(r_m_request), 0);
      chk("rst_grant", 32'(r_grant_idx), 0);
      chk("rst_s_busy", 32'(r_s_busy), 0);
      chk("rst_m_req_len", 32'(r_m_req_len), 0);
      chk("rst_timeout_err", 32'(r_timeout_err), 0);
      rst_n = 1'b1;

      // m_finish while idle is ignored
      m_finish = 1'b1;
      tick();
      chk("idle_fin_s_finish", 32'(r_s_finish), 0);
      chk("idle_fin_s_busy", 32'(r_s_busy), 0);
      m_finish = 1'b0;

      // single request on index 3, fields latched and withdrawal ignored
      s_req_len[3*24 +: 24]    = 24'd256;
      s_req_wr_len[3*24 +: 24] = 24'd17;
      s_req_cmd[3*3 +: 3]      = 3'd4;
      s_request = 8'h08;
      tick();
      chk("t1_m_request", 32'(r_m_request), 1);
      chk("t1_len", 32'(r_m_req_len), 256);
      chk("t1_wr_len", 32'(r_m_req_wr_len), 17);
      chk("t1_cmd", 32'(r_m_req_cmd), 4);
      chk("t1_grant", 32'(r_grant_idx), 3);
      chk("t1_s_busy", 32'(r_s_busy), 32'hFF);
      s_request = '0;
      s_req_len[3*24 +: 24] = 24'd7;
      s_req_cmd[3*3 +: 3]   = 3'd1;
      tick();
      chk("t1_hold_request", 32'(r_m_request), 1);
      chk("t1_hold_len", 32'(r_m_req_len), 256);
      chk("t1_hold_cmd", 32'(r_m_req_cmd), 4);
      m_busy = 1'b1;
      tick();
      chk("t1_wait_request", 32'(r_m_request), 0);
      m_busy = 1'b0; m_finish = 1'b1;
      tick();
      chk("t1_s_finish", 32'(r_s_finish), 32'h08);
      m_finish = 1'b0;
      tick();
      chk("t1_s_finish_once", 32'(r_s_finish), 0);
      chk("t1_idle_busy", 32'(r_s_busy), 0);

      // clock enable freezes state; muxes still follow the grant
      s_request = 8'h08; clk_en = 1'b0;
      tick();
      chk("ce_idle_request", 32'(r_m_request), 0);
      chk("ce_idle_busy", 32'(r_s_busy), 0);
      clk_en = 1'b1;
      tick();
      chk("ce_issue_request", 32'(r_m_request), 1);
      clk_en = 1'b0; m_busy = 1'b1; s_wr_vld = 8'h08;
      tick();
      chk("ce_frozen_request", 32'(r_m_request), 1);
      chk("ce_frozen_wr_vld", 32'(r_m_wr_vld), 1);
      s_wr_vld = '0; clk_en = 1'b1;
      tick();
      chk("ce_wait_request", 32'(r_m_request), 0);
      m_busy = 1'b0; s_request = '0; m_finish = 1'b1;
      tick();
      chk("ce_s_finish", 32'(r_s_finish), 32'h08);
      m_finish = 1'b0;
      tick();

      // all requesters held: RR rotates from 0, fixed priority stays on 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s_request = 8'hFF;
      for (int k = 0; k < 9; k++) serve(k % 8, 0);

      // requests 2 and 5 held
      s_request = 8'h24;
      serve(2, 2);
      serve(5, 2);
      serve(2, 2);

      // data path with grant 1
      s_request = 8'h02;
      tick();
      chk("dp_grant", 32'(r_grant_idx), 1);
      s_request = '0;
      s_wr_vld = 8'h03;
      s_wr_data[1*D +: D] = 8'hA5;
      s_wr_data[0*D +: D] = 8'h3C;
      m_wr_ready = 1'b1; s_rd_ready = 8'h02; m_rd_vld = 1'b1; m_rd_data = 8'h5E;
      #1;
      chk("dp_m_wr_data", 32'(r_m_wr_data), 32'hA5);
      chk("dp_m_wr_vld", 32'(r_m_wr_vld), 1);
      chk("dp_s_wr_ready", 32'(r_s_wr_ready), 32'h02);
      chk("dp_m_rd_ready", 32'(r_m_rd_ready), 1);
      chk("dp_s_rd_vld", 32'(r_s_rd_vld), 32'h02);
      chk("dp_s_rd_data", 32'(r_s_rd_data), 32'h5E);
      m_finish = 1'b1;
      tick();
      m_finish = 1'b0;
      tick();
      chk("dp_idle_wr_vld", 32'(r_m_wr_vld), 0);
      chk("dp_idle_wr_ready", 32'(r_s_wr_ready), 0);
      chk("dp_idle_rd_vld", 32'(r_s_rd_vld), 0);
      chk("dp_idle_rd_ready", 32'(r_m_rd_ready), 0);
      s_wr_vld = '0; m_wr_ready = 1'b0; s_rd_ready = '0; m_rd_vld = 1'b0;

      // reset during WAIT_FIN aborts with no finish pulse
      s_request = 8'h40;
      tick();
      chk("ra_grant", 32'(r_grant_idx), 6);
      s_request = '0; m_busy = 1'b1;
      tick();
      chk("ra_busy", 32'(r_s_busy), 32'hFF);
      rst_n = 1'b0;
      #1;
      chk("ra_m_request", 32'(r_m_request), 0);
      chk("ra_s_busy", 32'(r_s_busy), 0);
      chk("ra_grant_rst", 32'(r_grant_idx), 0);
      chk("ra_len", 32'(r_m_req_len), 0);
      chk("ra_cmd", 32'(r_m_req_cmd), 0);
      m_busy = 1'b0; m_finish = 1'b1;
      tick();
      chk("ra_s_finish", 32'(r_s_finish), 0);
      m_finish = 1'b0; rst_n = 1'b1;
      s_request = 8'h11;
      serve(0, 0);
      serve(4, 0);
      s_request = '0;

`ifdef SPI_REQ_ARB_TIMEOUT_EN
      s_request = 8'h20;
      tick();
      chk("to_grant", 32'(r_grant_idx), 5);
      s_request = '0;
      repeat (15) tick();
      chk("to_early_finish", 32'(r_s_finish), 0);
      chk("to_early_err", 32'(r_timeout_err), 0);
      tick();
      chk("to_s_finish", 32'(r_s_finish), 32'h20);
      chk("to_err", 32'(r_timeout_err), 1);
      chk("to_m_request", 32'(r_m_request), 0);
      tick();
      chk("to_err_sticky", 32'(r_timeout_err), 1);
`else
      chk("no_watchdog_err", 32'(r_timeout_err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
